// File: rtl/fxu_reservation_station.sv
// ---------------------------------------------------------------------------
// fxu_reservation_station
//
// Reservation station for one fixed-point unit. It is the receive end of the
// dispatch interface from the instruction buffer. It holds up to DEPTH
// instructions in a collapsing queue, where entry 0 is the oldest. Missing
// operands are captured from the common result bus (CDB) by ROB tag. The
// oldest fully-ready entry is issued to the ALU under a valid/ready handshake.
//
// Parameters
//   DEPTH   number of entries (2..8)
//   TAG_W   ROB index / operand owner width
//   DATA_W  operand value width
//
// Ports
//   clk, rst             clock (rising edge), async active-high reset
//   flush                synchronous clear of all entries (mispredict)
//   in_instr_valid ...   dispatch strobe and instruction fields, with
//                        per-operand {valid, value, owner}
//   full                 no free entry (registered count only)
//   cdb_*                result broadcast: valid, ROB tag, value
//   alu_ready            ALU accepts an issue this cycle
//   out_issue_valid ...  issue slot: valid flag and selected instruction
//                        fields; data fields are 0 while not valid
//   count                number of occupied entries
//
// Optional feature (macro FXU_RS_BYPASS_EN)
//   When the station is empty, a dispatched instruction whose operands are
//   both available drives the issue outputs in the same cycle. If the ALU
//   takes it, the instruction is never written into the queue.
// ---------------------------------------------------------------------------
module fxu_reservation_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_instr_valid,
  input  logic [TAG_W-1:0]           in_rob_idx,
  input  logic [3:0]                 in_opcode,
  input  logic [7:0]                 in_i,
  input  logic                       in_a_valid,
  input  logic [DATA_W-1:0]          in_a_value,
  input  logic [TAG_W-1:0]           in_a_owner,
  input  logic                       in_b_valid,
  input  logic [DATA_W-1:0]          in_b_value,
  input  logic [TAG_W-1:0]           in_b_owner,
  output logic                       full,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_rob_idx,
  input  logic [DATA_W-1:0]          cdb_value,
  input  logic                       alu_ready,
  output logic                       out_issue_valid,
  output logic [TAG_W-1:0]           out_rob_idx,
  output logic [3:0]                 out_opcode,
  output logic [7:0]                 out_i,
  output logic [DATA_W-1:0]          out_a_value,
  output logic [DATA_W-1:0]          out_b_value,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int SELW = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  rob;
    logic [3:0]        op;
    logic [7:0]        imm;
    logic              av;
    logic [DATA_W-1:0] a;
    logic [TAG_W-1:0]  ao;
    logic              bv;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  bo;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  // One spare slot past the end, kept empty, so the collapse can read k+1
  // for the top entry without going out of range.
  entry_t        woke  [DEPTH+1];
  logic [CW-1:0] count_q, count_d;

  logic [DEPTH-1:0] rdy;
  logic             any_rdy;
  logic [SELW-1:0]  sel;
  logic             q_issue;
  logic             issue_fire;
  logic             byp_valid;
  logic             byp_fire;
  logic             accept;
  logic [CW-1:0]    slot;
  entry_t           in_ent;

  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // Incoming instruction with dispatch-time CDB capture applied to each operand.
  always_comb begin
    in_ent       = '0;
    in_ent.valid = 1'b1;
    in_ent.rob   = in_rob_idx;
    in_ent.op    = in_opcode;
    in_ent.imm   = in_i;
    in_ent.ao    = in_a_owner;
    in_ent.bo    = in_b_owner;
    in_ent.av    = in_a_valid;
    in_ent.a     = in_a_value;
    in_ent.bv    = in_b_valid;
    in_ent.b     = in_b_value;
    if (!in_a_valid && cdb_valid && (cdb_rob_idx == in_a_owner)) begin
      in_ent.av = 1'b1;
      in_ent.a  = cdb_value;
    end
    if (!in_b_valid && cdb_valid && (cdb_rob_idx == in_b_owner)) begin
      in_ent.bv = 1'b1;
      in_ent.b  = cdb_value;
    end
  end

  // Readiness comes from registered state only. A wakeup in this cycle makes
  // an entry ready in the following cycle.
  always_comb begin
    rdy     = '0;
    any_rdy = 1'b0;
    sel     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      rdy[k] = ent_q[k].valid && ent_q[k].av && ent_q[k].bv;
    end
    // Scan from the top down so that the lowest-index (oldest) ready entry
    // wins.
    for (int unsigned k = DEPTH; k > 0; k--) begin
      if (rdy[k-1]) begin
        any_rdy = 1'b1;
        sel     = SELW'(k - 1);
      end
    end
  end

  assign q_issue    = any_rdy && !flush;
  assign issue_fire = q_issue && alu_ready;

`ifdef FXU_RS_BYPASS_EN
  assign byp_valid = (count_q == '0) && in_instr_valid && !flush && in_ent.av && in_ent.bv;
`else
  assign byp_valid = 1'b0;
`endif
  assign byp_fire = byp_valid && alu_ready;

  assign accept = in_instr_valid && !full && !flush && !byp_fire;
  assign slot   = count_q - CW'(issue_fire);

  // Issue outputs. The queue and the bypass are never both valid, because
  // the bypass only fires when the queue is empty.
  always_comb begin
    out_issue_valid = q_issue || byp_valid;
    out_rob_idx     = '0;
    out_opcode      = '0;
    out_i           = '0;
    out_a_value     = '0;
    out_b_value     = '0;
    if (q_issue) begin
      out_rob_idx = ent_q[sel].rob;
      out_opcode  = ent_q[sel].op;
      out_i       = ent_q[sel].imm;
      out_a_value = ent_q[sel].a;
      out_b_value = ent_q[sel].b;
    end else if (byp_valid) begin
      out_rob_idx = in_ent.rob;
      out_opcode  = in_ent.op;
      out_i       = in_ent.imm;
      out_a_value = in_ent.a;
      out_b_value = in_ent.b;
    end
  end

  // Next state. Wakeup is applied to every entry first, then the queue
  // collapses over the issued slot. Because of this order, entries shifting
  // down still see this cycle's CDB result. A new dispatch lands at the
  // post-collapse tail.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      woke[k] = ent_q[k];
      if (ent_q[k].valid && !ent_q[k].av && cdb_valid && (cdb_rob_idx == ent_q[k].ao)) begin
        woke[k].av = 1'b1;
        woke[k].a  = cdb_value;
      end
      if (ent_q[k].valid && !ent_q[k].bv && cdb_valid && (cdb_rob_idx == ent_q[k].bo)) begin
        woke[k].bv = 1'b1;
        woke[k].b  = cdb_value;
      end
    end
    woke[DEPTH] = '0;

    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (issue_fire && (k >= 32'(sel))) begin
        ent_d[k] = woke[k+1];
      end else begin
        ent_d[k] = woke[k];
      end
      if (accept && (CW'(k) == slot)) begin
        ent_d[k] = in_ent;
      end
    end

    count_d = count_q + CW'(accept) - CW'(issue_fire);

    if (flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ent_d[k] = '0;
      end
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ent_q[k] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ent_q[k] <= ent_d[k];
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fxu_reservation_station.sv
module tb_fxu_reservation_station;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 16;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_instr_valid;
  logic [TAG_W-1:0]  in_rob_idx;
  logic [3:0]        in_opcode;
  logic [7:0]        in_i;
  logic              in_a_valid;
  logic [DATA_W-1:0] in_a_value;
  logic [TAG_W-1:0]  in_a_owner;
  logic              in_b_valid;
  logic [DATA_W-1:0] in_b_value;
  logic [TAG_W-1:0]  in_b_owner;
  logic              full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_rob_idx;
  logic [DATA_W-1:0] cdb_value;
  logic              alu_ready;
  logic              out_issue_valid;
  logic [TAG_W-1:0]  out_rob_idx;
  logic [3:0]        out_opcode;
  logic [7:0]        out_i;
  logic [DATA_W-1:0] out_a_value;
  logic [DATA_W-1:0] out_b_value;
  logic [CW-1:0]     count;

  int vectors     = 0;
  int miscompares = 0;

  fxu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_instr_valid(in_instr_valid), .in_rob_idx(in_rob_idx), .in_opcode(in_opcode), .in_i(in_i),
    .in_a_valid(in_a_valid), .in_a_value(in_a_value), .in_a_owner(in_a_owner),
    .in_b_valid(in_b_valid), .in_b_value(in_b_value), .in_b_owner(in_b_owner),
    .full(full), .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_value(cdb_value),
    .alu_ready(alu_ready), .out_issue_valid(out_issue_valid), .out_rob_idx(out_rob_idx),
    .out_opcode(out_opcode), .out_i(out_i), .out_a_value(out_a_value), .out_b_value(out_b_value),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: an ordered list of waiting instructions, oldest first.
  typedef struct {
    logic [TAG_W-1:0]  rob;
    logic [3:0]        op;
    logic [7:0]        imm;
    bit                av;
    logic [DATA_W-1:0] a;
    logic [TAG_W-1:0]  ao;
    bit                bv;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  bo;
  } ent_t;

  ent_t mq[$];

  // Inputs change at posedge+1. At negedge, outputs are checked against the
  // model, and the model then advances to the state after the next edge.
  always @(negedge clk) begin
    int   sel;
    bit   e_valid;
    ent_t e;
    ent_t n;
    if (rst) mq.delete();
    sel = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].av && mq[i].bv) begin
        sel = i;
        break;
      end
    end
    e_valid = (sel >= 0) && !flush;
    e = '{default: '0};
    if (e_valid) e = mq[sel];
    chk("issue_valid", 32'(out_issue_valid), 32'(e_valid));
    chk("rob_idx",     32'(out_rob_idx),     32'(e.rob));
    chk("opcode",      32'(out_opcode),      32'(e.op));
    chk("imm",         32'(out_i),           32'(e.imm));
    chk("a_value",     32'(out_a_value),     32'(e.a));
    chk("b_value",     32'(out_b_value),     32'(e.b));
    chk("count",       32'(count),           32'(mq.size()));
    chk("full",        32'(full),            32'(mq.size() == DEPTH));
    if (!rst) begin
      if (flush) begin
        mq.delete();
      end else begin
        bit fire;
        bit acc;
        fire = e_valid && alu_ready;
        acc  = in_instr_valid && (mq.size() < DEPTH);
        foreach (mq[i]) begin
          if (!mq[i].av && cdb_valid && cdb_rob_idx == mq[i].ao) begin mq[i].av = 1; mq[i].a = cdb_value; end
          if (!mq[i].bv && cdb_valid && cdb_rob_idx == mq[i].bo) begin mq[i].bv = 1; mq[i].b = cdb_value; end
        end
        if (fire) mq.delete(sel);
        if (acc) begin
          n.rob = in_rob_idx; n.op = in_opcode; n.imm = in_i;
          n.ao = in_a_owner;  n.bo = in_b_owner;
          n.av = in_a_valid || (cdb_valid && cdb_rob_idx == in_a_owner);
          n.a  = in_a_valid ? in_a_value : cdb_value;
          n.bv = in_b_valid || (cdb_valid && cdb_rob_idx == in_b_owner);
          n.b  = in_b_valid ? in_b_value : cdb_value;
          mq.push_back(n);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_instr_valid = 0; cdb_valid = 0; flush = 0;
  endtask

  task automatic disp(input logic [3:0] rob, input logic [3:0] op, input logic [7:0] imm,
                      input logic av, input logic [15:0] a, input logic [3:0] ao,
                      input logic bv, input logic [15:0] b, input logic [3:0] bo);
    in_instr_valid = 1; in_rob_idx = rob; in_opcode = op; in_i = imm;
    in_a_valid = av; in_a_value = a; in_a_owner = ao;
    in_b_valid = bv; in_b_value = b; in_b_owner = bo;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [15:0] val);
    cdb_valid = 1; cdb_rob_idx = tag; cdb_value = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; flush = 0; in_instr_valid = 0; in_rob_idx = 0; in_opcode = 0; in_i = 0;
    in_a_valid = 0; in_a_value = 0; in_a_owner = 0; in_b_valid = 0; in_b_value = 0; in_b_owner = 0;
    cdb_valid = 0; cdb_rob_idx = 0; cdb_value = 0; alu_ready = 1;
    #3;
    chk("lit_reset_count", 32'(count), 0);
    chk("lit_reset_full",  32'(full), 0);
    chk("lit_reset_valid", 32'(out_issue_valid), 0);
    tick(); tick(); rst = 0;

    // Basic dispatch and issue, with 1-cycle latency.
    disp(3, 2, 8'h11, 1, 16'h0005, 0, 1, 16'h0007, 0);
    tick(); idle(); #2;
    chk("lit_t1_valid", 32'(out_issue_valid), 1);
    chk("lit_t1_rob",   32'(out_rob_idx), 3);
    chk("lit_t1_op",    32'(out_opcode), 2);
    chk("lit_t1_a",     32'(out_a_value), 32'h0005);
    chk("lit_t1_b",     32'(out_b_value), 32'h0007);
    tick(); #2;
    chk("lit_t1_count0", 32'(count), 0);

    // Fill to full. A dispatch while full is dropped. A CDB broadcast then
    // wakes all entries, which issue in dispatch order.
    for (int k = 0; k < 4; k++) begin
      disp(4'(10 + k), 1, 8'(k), 1, 16'(16'h0100 + k), 0, 0, 0, 9);
      tick();
    end
    idle(); #2;
    chk("lit_t2_full",  32'(full), 1);
    chk("lit_t2_count", 32'(count), 4);
    disp(14, 1, 8'h44, 1, 16'h0104, 0, 0, 0, 9);
    tick(); idle(); #2;
    chk("lit_t2_count_hold", 32'(count), 4);
    chk("lit_t2_none_ready", 32'(out_issue_valid), 0);
    cdb(9, 16'h1234);
    tick(); idle();
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("lit_t2_rob", 32'(out_rob_idx), 32'(10 + k));
      chk("lit_t2_b",   32'(out_b_value), 32'h1234);
      tick();
    end
    #2;
    chk("lit_t2_drained", 32'(count), 0);

    // Oldest-ready selection and collapse.
    disp(1, 3, 0, 1, 16'h000A, 0, 0, 0, 5); tick();
    disp(2, 3, 0, 1, 16'h000B, 0, 0, 0, 6); tick();
    disp(4, 5, 0, 1, 16'h0044, 0, 1, 16'h0045, 0); tick();
    idle(); #2;
    chk("lit_t3_first", 32'(out_rob_idx), 4);
    chk("lit_t3_count", 32'(count), 3);
    tick(); #2;
    chk("lit_t3_wait", 32'(out_issue_valid), 0);
    cdb(6, 16'h0066);
    tick(); idle(); #2;
    chk("lit_t3_second", 32'(out_rob_idx), 2);
    chk("lit_t3_b",      32'(out_b_value), 32'h0066);
    tick(); #2;
    chk("lit_t3_count1", 32'(count), 1);
    cdb(5, 16'h0055);
    tick(); idle(); #2;
    chk("lit_t3_third", 32'(out_rob_idx), 1);
    tick(); #2;

    // Dispatch-time CDB capture.
    disp(7, 6, 8'hA5, 0, 16'h0000, 4, 1, 16'h0001, 0);
    cdb(4, 16'hBEEF);
    tick(); idle(); #2;
    chk("lit_t4_valid", 32'(out_issue_valid), 1);
    chk("lit_t4_a",     32'(out_a_value), 32'hBEEF);
    chk("lit_t4_i",     32'(out_i), 32'hA5);
    tick(); #2;

    // Backpressure: outputs hold while the ALU is not ready.
    alu_ready = 0;
    disp(8, 9, 8'h08, 1, 16'h0808, 0, 1, 16'h0909, 0);
    tick(); idle();
    repeat (3) begin
      #2;
      chk("lit_t5_valid", 32'(out_issue_valid), 1);
      chk("lit_t5_rob",   32'(out_rob_idx), 8);
      chk("lit_t5_count", 32'(count), 1);
      tick();
    end
    alu_ready = 1;
    tick(); #2;
    chk("lit_t5_count0", 32'(count), 0);

    // Flush with three entries and a concurrent dispatch.
    alu_ready = 0;
    for (int k = 1; k <= 3; k++) begin
      disp(4'(k), 4'(k), 8'(k), 1, 16'(k), 0, 1, 16'(k), 0);
      tick();
    end
    idle(); #2;
    chk("lit_t6_count3", 32'(count), 3);
    alu_ready = 1;
    flush = 1;
    disp(9, 1, 0, 1, 16'h0099, 0, 1, 16'h0099, 0);
    #1;
    chk("lit_t6_flush_valid", 32'(out_issue_valid), 0);
    tick(); idle(); #2;
    chk("lit_t6_count", 32'(count), 0);
    chk("lit_t6_full",  32'(full), 0);
    chk("lit_t6_valid", 32'(out_issue_valid), 0);

    // Asynchronous reset in the middle of a cycle.
    alu_ready = 0;
    disp(1, 1, 0, 1, 16'h0001, 0, 1, 16'h0001, 0); tick();
    disp(2, 1, 0, 1, 16'h0002, 0, 1, 16'h0002, 0); tick();
    idle(); #1;
    rst = 1; #1;
    chk("lit_t7_count", 32'(count), 0);
    chk("lit_t7_valid", 32'(out_issue_valid), 0);
    tick(); rst = 0; alu_ready = 1;
    tick(); #2;
    chk("lit_t7_after", 32'(count), 0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
